// File: rtl/cntr_pkg.sv
// ---------------------------------------------------------------------------
// cntr_pkg
// Shared types and defaults for the counter command controller and its
// expected-value tracker.
//   cntr_op_e     : command opcodes (VERIFY / LOAD / INC / LOAD_INC)
//   cntr_state_e  : controller FSM states
//   CNTR_WIDTH_DEF: default counter data width
//   CNTR_LEN_W_DEF: default width of the increment burst length
// ---------------------------------------------------------------------------
package cntr_pkg;

  localparam int CNTR_WIDTH_DEF = 8;
  localparam int CNTR_LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_VERIFY   = 2'd0,
    OP_LOAD     = 2'd1,
    OP_INC      = 2'd2,
    OP_LOAD_INC = 2'd3
  } cntr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_INC    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } cntr_state_e;

  // True for the opcodes that start with a load cycle.
  function automatic logic op_has_load(input cntr_op_e op);
    return (op == OP_LOAD) || (op == OP_LOAD_INC);
  endfunction

endpackage

// File: rtl/cntr_exp_model.sv
// ---------------------------------------------------------------------------
// cntr_exp_model
// Tracks the value a load/increment counter must hold, given the same
// load/increment strobes the counter sees. Resets to 0 like the counter.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   ld_i     : load strobe (priority over inc_i)
//   inc_i    : increment strobe
//   data_i   : load value
//   exp_q_o  : expected counter value
// ---------------------------------------------------------------------------
module cntr_exp_model
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] exp_q_o
);

  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;

  always_comb begin
    exp_d = exp_q;
    if (ld_i) begin
      exp_d = data_i;
    end else if (inc_i) begin
      exp_d = exp_q + WIDTH'(1);  // wraps modulo 2^WIDTH
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_q_o = exp_q;

endmodule

// File: rtl/cntr_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// cntr_cmd_ctrl
// Accepts counter commands over a valid/ready handshake, drives the counter
// control port (data_in / ld / inc), tracks the expected counter value and
// checks the counter output q after every command.
// Optional feature macro: CNTR_CMD_CHECK_EN
//   defined   : q != exp_q in the CHECK cycle sets the sticky err flag
//   undefined : comparator removed, err tied 0 (timing unchanged)
// Ports:
//   clk, rst           : clock / asynchronous active-low reset
//   cmd_valid/ready    : command handshake (ready only in IDLE)
//   cmd_op/data/len    : opcode, load value, increment count
//   data_in, ld, inc   : counter control outputs (registered)
//   q                  : counter output read back
//   busy, done         : command in progress / one-cycle completion pulse
//   exp_q, err         : expected counter value / sticky mismatch flag
// ---------------------------------------------------------------------------
module cntr_cmd_ctrl
  import cntr_pkg::*;
#(
  parameter int WIDTH = CNTR_WIDTH_DEF,
  parameter int LEN_W = CNTR_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] data_in,
  output logic             ld,
  output logic             inc,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] exp_q,
  output logic             err
);

  cntr_state_e      state_q;
  cntr_op_e         op_q;
  logic [LEN_W-1:0] rem_q;       // increments still to issue, including current
  logic [WIDTH-1:0] data_in_q;
  logic             ld_q;
  logic             inc_q;
  logic             done_q;
  cntr_op_e         acc_op;
  logic [WIDTH-1:0] exp_q_w;

  assign acc_op = cntr_op_e'(cmd_op);

  // Strobes are registered together with the state they belong to, so each
  // output is high exactly in the cycle its state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_VERIFY;
      rem_q     <= '0;
      data_in_q <= '0;
      ld_q      <= 1'b0;
      inc_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ld_q   <= 1'b0;
      inc_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= acc_op;
            rem_q <= cmd_len;
            if (op_has_load(acc_op)) begin
              state_q   <= ST_LOAD;
              ld_q      <= 1'b1;
              data_in_q <= cmd_data;
            end else if (acc_op == OP_INC) begin
              if (cmd_len != '0) begin
                state_q <= ST_INC;
                inc_q   <= 1'b1;
              end else begin
                state_q <= ST_SETTLE;
              end
            end else begin
              state_q <= ST_CHECK;
              done_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (op_q == OP_LOAD_INC && rem_q != '0) begin
            state_q <= ST_INC;
            inc_q   <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_INC: begin
          if (rem_q == LEN_W'(1)) begin
            state_q <= ST_SETTLE;
          end else begin
            rem_q <= rem_q - LEN_W'(1);
            inc_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          state_q <= ST_CHECK;
          done_q  <= 1'b1;
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Expected value follows the same registered strobes the counter sees.
  cntr_exp_model #(
    .WIDTH (WIDTH)
  ) u_exp_model (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (ld_q),
    .inc_i   (inc_q),
    .data_i  (data_in_q),
    .exp_q_o (exp_q_w)
  );

`ifdef CNTR_CMD_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_q == ST_CHECK && q != exp_q_w) begin
      err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && state_q == ST_CHECK && q != exp_q_w) begin
      $error("cntr_cmd_ctrl: counter mismatch q=%h exp_q=%h", q, exp_q_w);
    end
  end
`endif

  assign err = err_q;
`else
  // Without the checker the counter readback has no consumer.
  logic unused_q;
  assign unused_q = ^q;
  assign err      = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ld        = ld_q;
  assign inc       = inc_q;
  assign data_in   = data_in_q;
  assign exp_q     = exp_q_w;

endmodule

// File: tb/tb_cntr_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cntr_cmd_ctrl
// Drives cntr_cmd_ctrl against a behavioural counter, with a cycle-by-cycle
// reference built from command latencies and pulse windows, plus directed
// literal expectations and randomized command streams.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cntr_cmd_ctrl;

  localparam int W  = 8;
  localparam int LW = 8;

`ifdef CNTR_CMD_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0]  data_in;
  logic          ld;
  logic          inc;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic [W-1:0]  exp_q;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cntr_cmd_ctrl #(
    .WIDTH (W),
    .LEN_W (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .data_in   (data_in),
    .ld        (ld),
    .inc       (inc),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .exp_q     (exp_q),
    .err       (err)
  );

  // Behavioural load/increment counter, with a fault override on q.
  logic [W-1:0] cnt_q;
  logic         fault = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst)     cnt_q <= '0;
    else if (ld)  cnt_q <= data_in;
    else if (inc) cnt_q <= cnt_q + W'(1);
  end
  assign q = fault ? '0 : cnt_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  bit           m_active = 1'b0;
  bit           m_load   = 1'b0;
  int           m_k = 0, m_lat = 0, m_s = 1, m_len = 0;
  logic [W-1:0] m_data = '0, m_exp = '0, m_din = '0;
  bit           m_err = 1'b0;

  // Expected counter value in cycle k of the current command.
  function automatic logic [W-1:0] exp_at(input int k);
    int           n;
    logic [W-1:0] b;
    b = (m_load && k >= 2) ? m_data : m_exp;
    n = k - m_s;
    if (n < 0) n = 0;
    if (n > m_len) n = m_len;
    return b + W'(n);
  endfunction

  always @(negedge clk) begin
    logic         e_ld, e_inc, e_done;
    logic [W-1:0] e_din, e_exp;
    logic [1:0]   op;
    if (!rst) begin
      m_active = 1'b0; m_exp = '0; m_din = '0; m_err = 1'b0;
    end
    e_ld = 1'b0; e_inc = 1'b0; e_done = 1'b0; e_din = m_din; e_exp = m_exp;
    if (m_active) begin
      e_ld   = m_load && (m_k == 1);
      e_inc  = (m_k >= m_s) && (m_k < m_s + m_len);
      e_done = (m_k == m_lat);
      if (m_load) e_din = m_data;
      e_exp  = exp_at(m_k);
    end
    chk("outputs{rdy,busy,ld,inc,done,err,din,expq}",
        {10'd0, cmd_ready, busy, ld, inc, done, err, data_in, exp_q},
        {10'd0, !m_active, m_active, e_ld, e_inc, e_done, m_err, e_din, e_exp});
    if (rst) begin
      if (m_active) begin
        if (m_k == m_lat) begin
          if (CHK_EN && q != e_exp) m_err = 1'b1;
          m_active = 1'b0;
          m_exp    = e_exp;
          m_din    = e_din;
        end else begin
          m_k++;
        end
      end else if (cmd_valid) begin
        op       = cmd_op;
        m_active = 1'b1;
        m_k      = 1;
        m_load   = (op == 2'd1) || (op == 2'd3);
        m_data   = cmd_data;
        m_s      = m_load ? 2 : 1;
        m_len    = (op >= 2'd2) ? int'(cmd_len) : 0;
        case (op)
          2'd0:    m_lat = 1;
          2'd1:    m_lat = 3;
          2'd2:    m_lat = m_len + 2;
          default: m_lat = m_len + 3;
        endcase
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d, input logic [LW-1:0] l,
                         input bit hold, output int lat, output int nld, output int ninc,
                         output logic [W-1:0] eq, output int w);
    lat = 0; nld = 0; ninc = 0; eq = '0; w = 0;
    @(posedge clk); #2;
    cmd_op = op; cmd_data = d; cmd_len = l; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      #1 cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    if (!hold) begin
      // Scramble inputs after acceptance: the captured command must stand.
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      cmd_len   = LW'($urandom);
    end
    do begin
      @(negedge clk);
      lat++;
      nld  += int'(ld);
      ninc += int'(inc);
    end while (!done && lat < 600);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    eq = exp_q;
    $display("cmd op=%0d data=%h len=%0d latency=%0d exp_q=%h q=%h err=%b",
             op, d, l, lat, exp_q, q, err);
  endtask

  initial begin
    int           lat, nld, ninc, w, ndone;
    logic [W-1:0] eq;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // VERIFY after reset
    run_cmd(2'd0, 8'h00, 8'd0, 1'b0, lat, nld, ninc, eq, w);
    chk("verify_latency", 32'(lat), 32'd1);
    chk("verify_exp_q", 32'(eq), 32'h00);
    chk("verify_err", 32'(err), 32'd0);

    // LOAD 0x5A
    run_cmd(2'd1, 8'h5A, 8'd7, 1'b0, lat, nld, ninc, eq, w);
    chk("load_latency", 32'(lat), 32'd3);
    chk("load_ld_pulses", 32'(nld), 32'd1);
    chk("load_inc_pulses", 32'(ninc), 32'd0);
    chk("load_exp_q", 32'(eq), 32'h5A);
    chk("load_q", 32'(q), 32'h5A);

    // LOAD_INC 0xFD len 4, wraps to 0x01
    run_cmd(2'd3, 8'hFD, 8'd4, 1'b0, lat, nld, ninc, eq, w);
    chk("ldinc_latency", 32'(lat), 32'd7);
    chk("ldinc_inc_pulses", 32'(ninc), 32'd4);
    chk("ldinc_exp_q", 32'(eq), 32'h01);
    chk("ldinc_q", 32'(q), 32'h01);

    // INC len 0 with cmd_valid held through busy, then INC len 3
    run_cmd(2'd2, 8'h00, 8'd0, 1'b1, lat, nld, ninc, eq, w);
    chk("inc0_latency", 32'(lat), 32'd2);
    chk("inc0_inc_pulses", 32'(ninc), 32'd0);
    run_cmd(2'd2, 8'h00, 8'd3, 1'b0, lat, nld, ninc, eq, w);
    chk("inc3_wait_after_done", 32'(w), 32'd0);
    chk("inc3_latency", 32'(lat), 32'd5);
    chk("inc3_exp_q", 32'(eq), 32'h04);

    // Randomized command stream
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), W'($urandom), LW'($urandom_range(0, 12)),
              ($urandom_range(0, 3) == 0), lat, nld, ninc, eq, w);
    end

    // Counter fault: q reads 0 after LOAD 0x33
    @(posedge clk); #2 fault = 1'b1;
    run_cmd(2'd1, 8'h33, 8'd0, 1'b0, lat, nld, ninc, eq, w);
    @(posedge clk); #2 fault = 1'b0;
    @(negedge clk);
    chk("fault_err", 32'(err), 32'(CHK_EN));
    run_cmd(2'd0, 8'h00, 8'd0, 1'b0, lat, nld, ninc, eq, w);
    chk("after_fault_exp_q", 32'(eq), 32'h33);
    chk("after_fault_q", 32'(q), 32'h33);
    chk("err_sticky", 32'(err), 32'(CHK_EN));

    // Reset during INC len 10
    @(posedge clk); #2;
    cmd_op = 2'd2; cmd_data = '0; cmd_len = 8'd10; cmd_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    @(posedge clk); #2 cmd_valid = 1'b0;
    $display("cmd op=2 data=00 len=10 (interrupted by reset)");
    repeat (3) @(posedge clk);
    #2;
    chk("inc_before_reset", 32'(inc), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_exp_q", 32'(exp_q), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cntr_cmd_ctrl.md
# cntr_cmd_ctrl

- Command-driven controller for the load/increment counter's control port: accepts high-level counter commands over a valid/ready handshake and drives `data_in`, `ld` and `inc` toward the counter.
- Tracks the value the counter must hold, reads `q` back after each command and flags mismatches.
- Sits between a test sequencer or CPU-side register block and the counter, on the same `clk`/`rst` as the counter.

## Interface
Parameters:
- WIDTH, 8, counter data width
- LEN_W, 8, width of increment burst length

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  0=VERIFY, 1=LOAD, 2=INC, 3=LOAD_INC
- cmd_data  input  WIDTH  load value
- cmd_len  input  LEN_W  number of increments
- data_in  output  WIDTH  load value to counter
- ld  output  1  counter load strobe
- inc  output  1  counter increment strobe
- q  input  WIDTH  counter output
- busy  output  1  command in progress
- done  output  1  one-cycle pulse, command complete
- exp_q  output  WIDTH  expected counter value
- err  output  1  sticky mismatch flag (see Configuration)

## Operation
- States: IDLE, LOAD, INC, SETTLE, CHECK.
- Handshake:
  - Command accepted on the rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` = (state == IDLE).
  - `cmd_op`, `cmd_data` and `cmd_len` are captured on acceptance; later input changes are ignored.
- IDLE on accept:
  - LOAD or LOAD_INC: go to LOAD.
  - INC with len>0: go to INC.
  - INC with len=0: go to SETTLE.
  - VERIFY: go to CHECK.
- LOAD: `ld`=1 and `data_in`=captured data for exactly one cycle; `exp_q` <= data. Next state:
  - INC if op=LOAD_INC and len>0;
  - otherwise SETTLE.
- INC: `inc`=1 for exactly len consecutive cycles. Each cycle, `exp_q` <= `exp_q`+1 mod 2^WIDTH (0xFF wraps to 0x00) and the remaining count decrements. When remaining==1, go to SETTLE.
- SETTLE: `ld`=`inc`=0 for one cycle so the counter's last update reaches `q`. Next state CHECK.
- CHECK:
  - `done`=1 for one cycle;
  - `q` is compared with `exp_q` (when the check is compiled in);
  - next state IDLE.
- `ld` and `inc` are never high together.
- `data_in` holds its last loaded value outside LOAD.
- `busy` = (state != IDLE).

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `ld`=0, `inc`=0, `data_in`=0, `exp_q`=0, `err`=0.
- The counter shares `rst`, so `exp_q`=0 after reset matches the counter's reset value.
- Reset mid-command: the command is abandoned and no `done` is produced.
- All outputs are decoded from registered state/data (Moore); there is no combinational path from inputs to outputs.
- Latency from the accept edge to the `done` cycle (cycle 1 = first cycle after accept):
  - VERIFY: done in cycle 1.
  - LOAD: done in cycle 3.
  - INC with len=N: done in cycle N+2.
  - LOAD_INC with len=N: done in cycle N+3.
- A new command can be accepted in the cycle after `done`. Back-to-back throughput is therefore latency+1 cycles per command.

## Configuration
- Macro `CNTR_CMD_CHECK_EN`.
- Defined:
  - In CHECK, mismatch `q != exp_q` sets `err`.
  - `err` stays set until reset.
  - On each mismatch, a simulation-only `$error` reports `q` and `exp_q`.
- Undefined:
  - Comparator and `err` flop are removed; `err` is tied 0.
  - `exp_q` is still tracked.
  - Timing is identical, including the CHECK cycle.

## Structure
- Package `cntr_pkg` holds:
  - `cntr_op_e` (VERIFY/LOAD/INC/LOAD_INC, 2-bit);
  - `cntr_state_e`;
  - the default WIDTH/LEN_W constants.
- One sub-module, `cntr_exp_model`: the expected-value tracker, with load/inc strobes in and `exp_q` out, reset to 0. It is reused by testbench scoreboards.
- FSM, handshake and checker live in `cntr_cmd_ctrl`.

## Test plan
- Reset, then VERIFY → `done` in cycle 1; `exp_q`=0x00; `err`=0.
- LOAD 0x5A → `ld` high for 1 cycle with `data_in`=0x5A; `done` in cycle 3; `q`=0x5A; `err`=0.
- LOAD_INC data=0xFD, len=4 → 4 `inc` pulses; wrap to 0x01; `exp_q`=`q`=0x01; `done` in cycle 7.
- INC len=0 → no `inc` pulse; `done` in cycle 2. Also: `cmd_valid` held during `busy` is not accepted until IDLE.
- Inject a counter fault (force `q`=0x00 after LOAD 0x33) → `err`=1, remains 1 through later passing commands; `err`=0 with the macro undefined.
- Assert `rst` during INC len=10 → immediately `ld`=`inc`=0, `cmd_ready`=1, `exp_q`=0, no `done`.
